// File: rtl/d5m_video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : d5m_video_pkg
// Description : Shared types and default constants for the D5M pixel-stream
//               to AXI4-Stream video packer.
// Revision    : 1.0 - initial release
// ============================================================================
package d5m_video_pkg;

    // Default pixel width (8 bits each of R, G, B) and coordinate width
    localparam int c_DATA_W  = 24;
    localparam int c_COORD_W = 12;

    // One AXI4-Stream video beat as stored in the beat FIFO
    typedef struct packed {
        logic [c_DATA_W-1:0] tdata;
        logic                tuser;
        logic                tlast;
    } axis_beat_t;

    // Line/frame tracker states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LINE = 2'd1,
        GAP  = 2'd2
    } trk_state_t;

endpackage
`default_nettype wire

// File: rtl/axis_beat_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis_beat_fifo
// Description : Synchronous FIFO of axis_beat_t with a registered output
//               stage. Total capacity (memory plus output register) is
//               FIFO_DEPTH beats. A push into a full FIFO is accepted when a
//               pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_beat_fifo
    import d5m_video_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
)
(
    input  logic       ACLK,
    input  logic       ARESETN,
    input  logic       i_push,
    input  axis_beat_t i_beat,
    input  logic       i_ready,
    output axis_beat_t o_beat,
    output logic       o_full,
    output logic       o_empty
);

    localparam int               c_AW        = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]    c_DEPTH_CNT = (c_AW+1)'(FIFO_DEPTH);

    axis_beat_t      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_mem_cnt;
    logic            r_out_valid;
    axis_beat_t      r_out_beat;

    logic w_pop;
    logic w_out_free;
    logic w_mem_empty;
    logic w_full;
    logic w_wr_ok;
    logic w_bypass;
    logic w_mem_wr;
    logic w_mem_rd;

    // Occupancy, write acceptance and routing of the incoming beat
    always_comb begin
        w_pop       = r_out_valid & i_ready;
        w_out_free  = ~r_out_valid | w_pop;
        w_mem_empty = (r_mem_cnt == '0);
        w_full      = ((r_mem_cnt + {{c_AW{1'b0}}, r_out_valid}) == c_DEPTH_CNT);
        w_wr_ok     = i_push & (~w_full | w_pop);
        // An empty FIFO loads the output register directly so a beat is
        // visible the cycle after it is pushed.
        w_bypass    = w_wr_ok & w_out_free & w_mem_empty;
        w_mem_wr    = w_wr_ok & ~w_bypass;
        w_mem_rd    = w_out_free & ~w_mem_empty;
    end

    // Storage array write port (no reset needed on the data)
    always_ff @(posedge ACLK) begin
        if (w_mem_wr) begin
            r_mem[r_wr_ptr] <= i_beat;
        end
    end

    // Pointers, count and the registered output stage
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_beat  <= '0;
        end else begin
            if (w_mem_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_mem_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_mem_wr, w_mem_rd})
                2'b10:   r_mem_cnt <= r_mem_cnt + 1'b1;
                2'b01:   r_mem_cnt <= r_mem_cnt - 1'b1;
                default: r_mem_cnt <= r_mem_cnt;
            endcase
            if (w_out_free) begin
                if (!w_mem_empty) begin
                    r_out_valid <= 1'b1;
                    r_out_beat  <= r_mem[r_rd_ptr];
                end else if (w_bypass) begin
                    r_out_valid <= 1'b1;
                    r_out_beat  <= i_beat;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign o_beat  = r_out_beat;
    assign o_full  = w_full;
    assign o_empty = ~r_out_valid;

endmodule
`default_nettype wire

// File: rtl/d5m_video_axis_packer.sv
`default_nettype none
// ============================================================================
// Module      : d5m_video_axis_packer
// Description : Packs the D5M RGB pixel stream (line/frame valid qualified)
//               into AXI4-Stream video with tuser (start of frame) and
//               tlast (end of line), buffered by a small beat FIFO.
//               Optional build macro D5M_PACKER_COORD_EN adds pixel
//               coordinate counters and the endOfFrame pulse; without it
//               those outputs are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module d5m_video_axis_packer
    import d5m_video_pkg::*;
#(
    parameter int DATA_W     = c_DATA_W,
    parameter int FIFO_DEPTH = 16,
    parameter int COORD_W    = c_COORD_W
)
(
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic [DATA_W-1:0]  iRgb,
    input  logic               ilvalid,
    input  logic               ifvalid,
    input  logic               rgb_m_axis_tready,
    output logic               rgb_m_axis_tvalid,
    output logic [DATA_W-1:0]  rgb_m_axis_tdata,
    output logic               rgb_m_axis_tuser,
    output logic               rgb_m_axis_tlast,
    output logic [COORD_W-1:0] xCord,
    output logic [COORD_W-1:0] yCord,
    output logic               endOfFrame,
    output logic               overflow
);

    logic       r_acc_d;
    logic       r_fv_d;
    logic       r_fv_known;
    logic       r_sof_pend;
    logic       r_hold_valid;
    axis_beat_t r_hold;
    logic       r_overflow;

    logic       w_acc;
    logic       w_line_end;
    logic       w_fv_rise;
    logic       w_fv_fall;
    logic       w_tuser;
    logic       w_push;
    axis_beat_t w_push_beat;
    axis_beat_t w_fifo_beat;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_pop;

    // Accept/edge detection and the beat leaving the hold register
    always_comb begin
        w_acc       = ilvalid & ifvalid;
        w_line_end  = r_acc_d & ~w_acc;
        // Frame edges only count once ifvalid has been seen low since reset,
        // so a frame already in flight at reset release is never a start.
        w_fv_rise   = ifvalid & ~r_fv_d & r_fv_known;
        w_fv_fall   = ~ifvalid & r_fv_d & r_fv_known;
        w_tuser     = r_sof_pend | w_fv_rise;
        w_push      = r_hold_valid & (w_acc | w_line_end | w_fv_fall);
        // The held beat is last-of-line unless another pixel follows now
        w_push_beat = {r_hold.tdata, r_hold.tuser, ~w_acc};
        w_pop       = ~w_fifo_empty & rgb_m_axis_tready;
    end

    // Input history, start-of-frame tracking, hold register, overflow flag
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_acc_d      <= 1'b0;
            r_fv_d       <= 1'b0;
            r_fv_known   <= 1'b0;
            r_sof_pend   <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_acc_d <= w_acc;
            r_fv_d  <= ifvalid;
            if (!ifvalid) begin
                r_fv_known <= 1'b1;
            end
            if (w_acc) begin
                r_sof_pend <= 1'b0;
            end else if (w_fv_rise) begin
                r_sof_pend <= 1'b1;
            end else if (w_fv_fall) begin
                r_sof_pend <= 1'b0;
            end
            if (w_acc) begin
                r_hold_valid <= 1'b1;
                r_hold       <= {iRgb, w_tuser, 1'b0};
            end else if (w_push) begin
                r_hold_valid <= 1'b0;
            end
            if (w_push && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    axis_beat_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .i_push  (w_push),
        .i_beat  (w_push_beat),
        .i_ready (rgb_m_axis_tready),
        .o_beat  (w_fifo_beat),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign rgb_m_axis_tvalid = ~w_fifo_empty;
    assign rgb_m_axis_tdata  = w_fifo_beat.tdata;
    assign rgb_m_axis_tuser  = w_fifo_beat.tuser;
    assign rgb_m_axis_tlast  = w_fifo_beat.tlast;
    assign overflow          = r_overflow;

`ifdef D5M_PACKER_COORD_EN
    trk_state_t         r_state;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_eof;

    // Tracker FSM with saturating column/row counters and frame-end pulse
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_eof   <= 1'b0;
        end else begin
            r_eof <= w_fv_fall;
            if (w_fv_fall) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_acc) begin
                            r_state <= LINE;
                            r_x     <= '0;
                            r_y     <= '0;
                        end
                    end
                    LINE: begin
                        if (w_acc) begin
                            r_x <= (&r_x) ? r_x : r_x + 1'b1;
                        end else if (w_line_end) begin
                            r_state <= GAP;
                        end
                    end
                    GAP: begin
                        if (w_acc) begin
                            r_state <= LINE;
                            r_x     <= '0;
                            r_y     <= (&r_y) ? r_y : r_y + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign xCord      = r_x;
    assign yCord      = r_y;
    assign endOfFrame = r_eof;
`else
    assign xCord      = '0;
    assign yCord      = '0;
    assign endOfFrame = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_d5m_video_axis_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_d5m_video_axis_packer
// Description : Self-checking bench for d5m_video_axis_packer. Expected beats
//               are queued as pixels are driven and compared when the DUT
//               hands them off; directed checks cover reset, latency,
//               overflow, backpressure and reset mid-frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_d5m_video_axis_packer;

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
    } exp_t;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [23:0] iRgb;
    logic        ilvalid;
    logic        ifvalid;
    logic        rgb_m_axis_tready = 1'b1;
    logic        rgb_m_axis_tvalid;
    logic [23:0] rgb_m_axis_tdata;
    logic        rgb_m_axis_tuser;
    logic        rgb_m_axis_tlast;
    logic [11:0] xCord;
    logic [11:0] yCord;
    logic        endOfFrame;
    logic        overflow;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_rx  = 0;
    int   n_eof = 0;
    int   rdy_mode = 0;
    exp_t exp_q[$];

    logic        stall_prev = 1'b0;
    logic [25:0] prev_beat  = '0;

    d5m_video_axis_packer #(
        .DATA_W     (24),
        .FIFO_DEPTH (16),
        .COORD_W    (12)
    ) dut (
        .ACLK              (ACLK),
        .ARESETN           (ARESETN),
        .iRgb              (iRgb),
        .ilvalid           (ilvalid),
        .ifvalid           (ifvalid),
        .rgb_m_axis_tready (rgb_m_axis_tready),
        .rgb_m_axis_tvalid (rgb_m_axis_tvalid),
        .rgb_m_axis_tdata  (rgb_m_axis_tdata),
        .rgb_m_axis_tuser  (rgb_m_axis_tuser),
        .rgb_m_axis_tlast  (rgb_m_axis_tlast),
        .xCord             (xCord),
        .yCord             (yCord),
        .endOfFrame        (endOfFrame),
        .overflow          (overflow)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: always, never, or 3-in-4 pseudo-random
    always @(posedge ACLK) begin
        #1;
        case (rdy_mode)
            0:       rgb_m_axis_tready = 1'b1;
            1:       rgb_m_axis_tready = 1'b0;
            default: rgb_m_axis_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Output monitor: scoreboard pops, stall stability, frame-end pulses
    always @(negedge ACLK) begin
        logic [25:0] cur;
        exp_t        e;
        cur = {rgb_m_axis_tdata, rgb_m_axis_tuser, rgb_m_axis_tlast};
        if (!ARESETN) begin
            stall_prev = 1'b0;
        end else begin
            if (endOfFrame) n_eof++;
            if (stall_prev) begin
                chk("stall_tvalid", 64'(rgb_m_axis_tvalid), 64'd1);
                chk("stall_beat", 64'(cur), 64'(prev_beat));
            end
            if (rgb_m_axis_tvalid && rgb_m_axis_tready) begin
                n_rx++;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 64'(cur), 64'({e.d, e.u, e.l}));
                end
            end
            stall_prev = rgb_m_axis_tvalid & ~rgb_m_axis_tready;
            prev_beat  = cur;
        end
    end

    task automatic step(input logic lv, input logic fv, input logic [23:0] px);
        @(posedge ACLK);
        #1;
        ilvalid = lv;
        ifvalid = fv;
        iRgb    = px;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tvalid"}, 64'(rgb_m_axis_tvalid), 64'd0);
        chk({tag, "_tdata"},  64'(rgb_m_axis_tdata),  64'd0);
        chk({tag, "_tuser"},  64'(rgb_m_axis_tuser),  64'd0);
        chk({tag, "_tlast"},  64'(rgb_m_axis_tlast),  64'd0);
        chk({tag, "_xcord"},  64'(xCord),             64'd0);
        chk({tag, "_ycord"},  64'(yCord),             64'd0);
        chk({tag, "_eof"},    64'(endOfFrame),        64'd0);
        chk({tag, "_ovf"},    64'(overflow),          64'd0);
    endtask

    // Full frame: w x h pixels, gap idle cycles after each line
    task automatic send_frame(input int w, input int h, input logic [23:0] base,
                              input int gap, input bit chk_lat);
        logic [23:0] px;
        exp_t        e;
        step(1'b0, 1'b1, 24'h0);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                px  = base + 24'(y * w + x);
                e.d = px;
                e.u = (x == 0 && y == 0);
                e.l = (x == w - 1);
                exp_q.push_back(e);
                step(1'b1, 1'b1, px);
                if (chk_lat && y == 0 && x < 3) begin
                    @(negedge ACLK);
                    chk("latency_tvalid", 64'(rgb_m_axis_tvalid), (x == 2) ? 64'd1 : 64'd0);
                end
            end
            for (int g = 0; g < gap; g++) step(1'b0, 1'b1, 24'h0);
        end
        step(1'b0, 1'b0, 24'h0);
        step(1'b0, 1'b0, 24'h0);
    endtask

    task automatic drain(input int budget, input string tag);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge ACLK);
            i++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
        repeat (5) step(1'b0, 1'b0, 24'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rx0;
        int   eof0;
        exp_t e;

        ARESETN = 1'b0;
        ilvalid = 1'b0;
        ifvalid = 1'b0;
        iRgb    = '0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_zero("reset");
        @(posedge ACLK);
        #1 ARESETN = 1'b1;
        repeat (3) step(1'b0, 1'b0, 24'h0);

        // Plain 4x2 frame with latency check on the first beat
        rx0  = n_rx;
        eof0 = n_eof;
        send_frame(4, 2, 24'h000001, 3, 1'b1);
        drain(200, "plain_drain");
        chk("plain_count", 64'(n_rx - rx0), 64'd8);
`ifdef D5M_PACKER_COORD_EN
        chk("plain_eof", 64'(n_eof - eof0), 64'd1);
        chk("plain_xcord", 64'(xCord), 64'd3);
        chk("plain_ycord", 64'(yCord), 64'd1);
`else
        chk("plain_eof", 64'(n_eof - eof0), 64'd0);
        chk("plain_xcord", 64'(xCord), 64'd0);
        chk("plain_ycord", 64'(yCord), 64'd0);
`endif

        // Single-pixel frame: beat visible one cycle after ilvalid falls
        rx0 = n_rx;
        step(1'b0, 1'b1, 24'h0);
        e.d = 24'hABCDEF;
        e.u = 1'b1;
        e.l = 1'b1;
        exp_q.push_back(e);
        step(1'b1, 1'b1, 24'hABCDEF);
        step(1'b0, 1'b1, 24'h0);
        @(negedge ACLK);
        chk("onepx_early", 64'(rgb_m_axis_tvalid), 64'd0);
        @(negedge ACLK);
        chk("onepx_tvalid", 64'(rgb_m_axis_tvalid), 64'd1);
        chk("onepx_beat", 64'({rgb_m_axis_tdata, rgb_m_axis_tuser, rgb_m_axis_tlast}),
            64'({24'hABCDEF, 1'b1, 1'b1}));
        step(1'b0, 1'b0, 24'h0);
        drain(50, "onepx_drain");
        chk("onepx_count", 64'(n_rx - rx0), 64'd1);
        chk("onepx_xcord", 64'(xCord), 64'd0);
        chk("onepx_ycord", 64'(yCord), 64'd0);

        // Backpressure: 16x4 frame with random tready
        rx0 = n_rx;
        rdy_mode = 2;
        send_frame(16, 4, 24'h001000, 6, 1'b0);
        drain(2000, "bp_drain");
        rdy_mode = 0;
        repeat (2) step(1'b0, 1'b0, 24'h0);
        chk("bp_count", 64'(n_rx - rx0), 64'd64);
        chk("bp_overflow", 64'(overflow), 64'd0);

        // Overflow: 32-pixel line into a stalled 16-entry FIFO
        rx0 = n_rx;
        rdy_mode = 1;
        repeat (3) step(1'b0, 1'b0, 24'h0);
        step(1'b0, 1'b1, 24'h0);
        for (int i = 0; i < 32; i++) begin
            if (i < 16) begin
                e.d = 24'h002000 + 24'(i);
                e.u = (i == 0);
                e.l = 1'b0;
                exp_q.push_back(e);
            end
            step(1'b1, 1'b1, 24'h002000 + 24'(i));
            if (i == 17) begin
                @(negedge ACLK);
                chk("ovf_before", 64'(overflow), 64'd0);
            end
            if (i == 18) begin
                @(negedge ACLK);
                chk("ovf_set", 64'(overflow), 64'd1);
            end
        end
        step(1'b0, 1'b1, 24'h0);
        step(1'b0, 1'b0, 24'h0);
        rdy_mode = 0;
        drain(200, "ovf_drain");
        chk("ovf_count", 64'(n_rx - rx0), 64'd16);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Reset mid-line: frame 1 discarded, frame 2 intact
        rdy_mode = 1;
        step(1'b0, 1'b1, 24'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 24'h003000 + 24'(i));
        @(posedge ACLK);
        #2;
        ARESETN = 1'b0;
        ilvalid = 1'b0;
        ifvalid = 1'b0;
        exp_q.delete();
        rdy_mode = 0;
        #1;
        check_zero("midrst");
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        repeat (3) step(1'b0, 1'b0, 24'h0);
        rx0 = n_rx;
        send_frame(4, 2, 24'h000100, 3, 1'b0);
        drain(200, "rst_drain");
        chk("rst_count", 64'(n_rx - rx0), 64'd8);
        chk("rst_overflow", 64'(overflow), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
